// File: rtl/axum_dbg_host_if.sv
// axum_dbg_host_if: byte command/response streams plus host bus of the debug host
interface axum_dbg_host_if;
  logic        cmd_valid_i;
  logic [7:0]  cmd_data_i;
  logic        cmd_ready_o;
  logic        rsp_valid_o;
  logic [7:0]  rsp_data_o;
  logic        rsp_ready_i;
  logic        host_req_o;
  logic        host_gnt_i;
  logic [31:0] host_addr_o;
  logic        host_we_o;
  logic [3:0]  host_be_o;
  logic [31:0] host_wdata_o;
  logic        host_rvalid_i;
  logic [31:0] host_rdata_i;
  logic        host_err_i;
  logic        busy_o;
  modport slave (
    input  cmd_valid_i, cmd_data_i, rsp_ready_i, host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, host_req_o, host_addr_o, host_we_o, host_be_o,
           host_wdata_o, busy_o
  );
  modport master (
    output cmd_valid_i, cmd_data_i, rsp_ready_i, host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, host_req_o, host_addr_o, host_we_o, host_be_o,
           host_wdata_o, busy_o
  );
endinterface

// File: rtl/axum_dbg_host.sv
// axum_dbg_host: byte-stream command decoder that issues one 32-bit host bus access and reports status
module axum_dbg_host #(
  parameter int TimeoutCycles = 1024
) (
  input logic            clk_i,
  input logic            rst_i,
  axum_dbg_host_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_RSP} state_t;
  localparam logic [31:0] TMO_LAST = 32'(TimeoutCycles - 1);
  state_t      r_state, w_next;
  logic        r_live;
  logic        r_we;
  logic [1:0]  r_idx;
  logic [31:0] r_addr, r_wdata, r_rdata, r_cnt;
  logic [7:0]  r_code;
  logic [2:0]  r_ridx, r_rlen;
  logic        w_cmd_fire, w_rsp_fire, w_tmo, w_known;
  logic [7:0]  w_rbyte;
  assign w_cmd_fire = bus.cmd_valid_i & bus.cmd_ready_o;
  assign w_rsp_fire = bus.rsp_valid_o & bus.rsp_ready_i;
  assign w_tmo      = (TimeoutCycles != 0) && (r_cnt == TMO_LAST);
  assign w_known    = (bus.cmd_data_i == 8'h57) || (bus.cmd_data_i == 8'h52);
  assign w_rbyte    = r_ridx == 3'd1 ? r_rdata[7:0] : r_ridx == 3'd2 ? r_rdata[15:8] :
                      r_ridx == 3'd3 ? r_rdata[23:16] : r_rdata[31:24];
  // State register; asynchronous reset abandons any transaction in flight
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_cmd_fire) w_next = w_known ? S_ADDR : S_RSP;
      S_ADDR: if (w_cmd_fire && r_idx == 2'd3) w_next = r_we ? S_DATA : S_REQ;
      S_DATA: if (w_cmd_fire && r_idx == 2'd3) w_next = S_REQ;
      S_REQ:  w_next = bus.host_gnt_i ? S_WAIT : w_tmo ? S_RSP : S_REQ;
      S_WAIT: if (bus.host_rvalid_i) w_next = S_RSP;
      S_RSP:  if (w_rsp_fire && r_ridx == r_rlen) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // Outputs decoded from state; r_live keeps cmd_ready low until the first edge after reset
  always_comb begin
    bus.cmd_ready_o  = r_live && (r_state == S_IDLE || r_state == S_ADDR || r_state == S_DATA);
    bus.rsp_valid_o  = r_state == S_RSP;
    bus.rsp_data_o   = r_state == S_RSP ? (r_ridx == 3'd0 ? r_code : w_rbyte) : 8'h00;
    bus.host_req_o   = r_state == S_REQ;
    bus.host_addr_o  = {r_addr[31:2], 2'b00};
    bus.host_we_o    = r_we;
    bus.host_be_o    = {4{r_live}};
    bus.host_wdata_o = r_wdata;
    bus.busy_o       = r_state != S_IDLE;
  end
  // Datapath: byte collection, REQ cycle counter, response capture and response byte index
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_live  <= 1'b0;
      r_we    <= 1'b0;
      r_idx   <= 2'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_cnt   <= 32'd0;
      r_code  <= 8'd0;
      r_ridx  <= 3'd0;
      r_rlen  <= 3'd0;
    end else begin
      r_live <= 1'b1;
      r_idx  <= r_state == S_IDLE ? 2'd0 : r_idx + {1'b0, w_cmd_fire};
      r_cnt  <= r_state == S_REQ ? r_cnt + 32'd1 : 32'd0;
      r_ridx <= r_state == S_RSP ? r_ridx + {2'b0, w_rsp_fire} : 3'd0;
      if (r_state == S_IDLE && w_cmd_fire) begin
        r_we   <= bus.cmd_data_i == 8'h57;
        r_code <= 8'h3F;
        r_rlen <= 3'd0;
      end
      if (r_state == S_ADDR && w_cmd_fire) r_addr <= {bus.cmd_data_i, r_addr[31:8]};
      if (r_state == S_DATA && w_cmd_fire) r_wdata <= {bus.cmd_data_i, r_wdata[31:8]};
      if (r_state == S_REQ && !bus.host_gnt_i && w_tmo) begin
        r_code <= 8'h54;
        r_rlen <= 3'd0;
      end
      if (r_state == S_WAIT && bus.host_rvalid_i) begin
        r_rdata <= bus.host_rdata_i;
        r_code  <= bus.host_err_i ? 8'h45 : 8'h4B;
        r_rlen  <= (!bus.host_err_i && !r_we) ? 3'd4 : 3'd0;
      end
    end
endmodule

// File: tb/tb_axum_dbg_host.sv
// tb_axum_dbg_host: scoreboard bench driving command bytes, a host bus responder and a response consumer
module tb_axum_dbg_host;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          gdly;
    int          len;
    bit          gnt;
    logic [31:0] rdata;
    bit          err;
  } bus_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  bus_t bq[$];
  logic [7:0] rq[$];
  bus_t cur;
  bit   in_req = 0;
  bit   pend = 0;
  int   rc = 0;
  bit   toggle = 0;
  bit   hold = 0;
  logic [7:0] held = 8'h00;
  axum_dbg_host_if bus ();
  axum_dbg_host #(.TimeoutCycles(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_data_i  = b;
    while (!bus.cmd_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("cmd_ready_tmo", 32'd0, 32'd1);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask
  task automatic push_bus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input int gdly, input int len, input bit gnt, input logic [31:0] rdata,
                          input bit err);
    bus_t e;
    e.addr = addr; e.we = we; e.wdata = wdata; e.gdly = gdly; e.len = len;
    e.gnt = gnt; e.rdata = rdata; e.err = err;
    bq.push_back(e);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((bus.busy_o || rq.size() != 0 || bq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_tmo", 32'd0, 32'd1);
  endtask
  // Host bus responder: checks each request against the scoreboard, grants and returns data
  initial begin
    bus.host_gnt_i = 1'b0; bus.host_rvalid_i = 1'b0; bus.host_rdata_i = 32'd0; bus.host_err_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.host_rvalid_i = 1'b0;
      bus.host_rdata_i  = $urandom;
      bus.host_err_i    = 1'($urandom_range(0, 1));
      if (rst) begin
        in_req = 0; pend = 0; rc = 0; bus.host_gnt_i = 1'b0;
      end else if (bus.host_req_o) begin
        if (!in_req) begin
          if (bq.size() == 0) begin
            check("bus_unexpected", 32'd1, 32'd0);
            cur.addr = bus.host_addr_o; cur.we = bus.host_we_o; cur.wdata = bus.host_wdata_o;
            cur.gdly = 0; cur.len = 1; cur.gnt = 1; cur.rdata = 32'd0; cur.err = 1'b1;
          end else cur = bq.pop_front();
          in_req = 1; rc = 0;
        end
        check("bus_addr", bus.host_addr_o, cur.addr);
        check("bus_we", {31'd0, bus.host_we_o}, {31'd0, cur.we});
        check("bus_be", {28'd0, bus.host_be_o}, 32'hF);
        if (cur.we) check("bus_wdata", bus.host_wdata_o, cur.wdata);
        rc++;
        bus.host_gnt_i = cur.gnt && rc > cur.gdly;
      end else begin
        bus.host_gnt_i = 1'b0;
        if (in_req) begin
          in_req = 0;
          check("req_len", rc, cur.len);
          pend = cur.gnt;
        end else if (pend) begin
          pend = 0;
          bus.host_rvalid_i = 1'b1;
          bus.host_rdata_i  = cur.rdata;
          bus.host_err_i    = cur.err;
        end
      end
    end
  end
  // Response consumer: pops expected bytes on each handshake and checks bytes hold while stalled
  initial begin
    bus.rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) hold = 0;
      else begin
        if (hold && bus.rsp_valid_o) check("rsp_hold", {24'd0, bus.rsp_data_o}, {24'd0, held});
        bus.rsp_ready_i = toggle ? ~bus.rsp_ready_i : 1'b1;
        if (bus.rsp_valid_o && bus.rsp_ready_i) begin
          hold = 0;
          if (rq.size() == 0) check("rsp_unexpected", {24'd0, bus.rsp_data_o}, 32'hFFFF_FFFF);
          else check("rsp_byte", {24'd0, bus.rsp_data_o}, {24'd0, rq.pop_front()});
        end else if (bus.rsp_valid_o) begin
          hold = 1;
          held = bus.rsp_data_o;
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_data_i  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("rst_rsp_data", {24'd0, bus.rsp_data_o}, 32'd0);
    check("rst_req", {31'd0, bus.host_req_o}, 32'd0);
    check("rst_addr", bus.host_addr_o, 32'd0);
    check("rst_we", {31'd0, bus.host_we_o}, 32'd0);
    check("rst_be", {28'd0, bus.host_be_o}, 32'd0);
    check("rst_wdata", bus.host_wdata_o, 32'd0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, bus.cmd_ready_o}, 32'd1);
    // Write with grant after two waiting cycles
    push_bus(32'h0010_0000, 1'b1, 32'hDEAD_BEEF, 2, 3, 1, 32'h0, 1'b0);
    rq.push_back(8'h4B);
    send_byte(8'h57); send_word(32'h0010_0000); send_word(32'hDEAD_BEEF);
    check("req_latency", {31'd0, bus.host_req_o}, 32'd1);
    wait_idle();
    // Read with consumer stalling every other cycle
    toggle = 1;
    push_bus(32'h0002_0004, 1'b0, 32'h0, 1, 2, 1, 32'h1234_5678, 1'b0);
    rq.push_back(8'h4B); rq.push_back(8'h78); rq.push_back(8'h56); rq.push_back(8'h34); rq.push_back(8'h12);
    send_byte(8'h52); send_word(32'h0002_0004);
    wait_idle();
    toggle = 0;
    // Unaligned read answered with an error
    push_bus(32'h0003_0000, 1'b0, 32'h0, 0, 1, 1, 32'hA5A5_A5A5, 1'b1);
    rq.push_back(8'h45);
    send_byte(8'h52); send_word(32'h0003_0003);
    wait_idle();
    // Grant never comes: request times out after 8 cycles
    push_bus(32'h0000_0010, 1'b0, 32'h0, 0, 8, 0, 32'h0, 1'b0);
    rq.push_back(8'h54);
    send_byte(8'h52); send_word(32'h0000_0010);
    wait_idle();
    // Unknown command byte
    rq.push_back(8'h3F);
    send_byte(8'h41);
    wait_idle();
    // Reset while waiting for grant
    push_bus(32'h0000_0100, 1'b0, 32'h0, 0, 0, 0, 32'h0, 1'b0);
    send_byte(8'h52); send_word(32'h0000_0100);
    repeat (3) @(negedge clk);
    check("pre_rst_req", {31'd0, bus.host_req_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", {31'd0, bus.host_req_o}, 32'd0);
    check("async_rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("async_rst_ready", {31'd0, bus.cmd_ready_o}, 32'd0);
    check("async_rst_addr", bus.host_addr_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst2", {31'd0, bus.cmd_ready_o}, 32'd1);
    repeat (4) @(negedge clk);
    check("no_bus_after_rst", {31'd0, bus.host_req_o}, 32'd0);
    check("no_rsp_after_rst", {31'd0, bus.rsp_valid_o}, 32'd0);
    // Full write after the abandoned read
    push_bus(32'h0000_0040, 1'b1, 32'hCAFE_F00D, 0, 1, 1, 32'h0, 1'b1);
    rq.push_back(8'h45);
    send_byte(8'h57); send_word(32'h0000_0041); send_word(32'hCAFE_F00D);
    wait_idle();
    push_bus(32'h0000_0080, 1'b1, 32'h0102_0304, 1, 2, 1, 32'h0, 1'b0);
    rq.push_back(8'h4B);
    send_byte(8'h57); send_word(32'h0000_0080); send_word(32'h0102_0304);
    wait_idle();
    check("bus_q_empty", bq.size(), 32'd0);
    check("rsp_q_empty", rq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
